// File: rtl/cpu_core_pkg.sv
// Shared definitions for the parametrised accumulator core: opcodes, FSM states,
// ALU operation codes and the instruction-width helper.
package cpu_core_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_JNZ  = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_OUT_WAIT = 3'd3,
    S_HALT     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_NONE = 3'd6
  } alu_op_e;

  // Instruction word: {opcode[3:0], reserved[3:0], imm[data_w-1:0]}
  function automatic int instr_width(input int data_w);
    return 8 + data_w;
  endfunction

endpackage

// File: rtl/cpu_alu_w.sv
// Combinational ALU: y = a op b, z = (y == 0), c = add carry-out or subtract borrow.
module cpu_alu_w
  import cpu_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] y_o,
  output logic              z_o,
  output logic              c_o
);

  logic [DATA_W:0] ext_s;

  // The extra top bit of the widened result is the carry (ADD) or borrow (SUB)
  always_comb begin
    ext_s = '0;
    y_o   = a_i;
    c_o   = 1'b0;
    case (op_i)
      ALU_PASS: y_o = b_i;
      ALU_ADD: begin
        ext_s = {1'b0, a_i} + {1'b0, b_i};
        y_o   = ext_s[DATA_W-1:0];
        c_o   = ext_s[DATA_W];
      end
      ALU_SUB: begin
        ext_s = {1'b0, a_i} - {1'b0, b_i};
        y_o   = ext_s[DATA_W-1:0];
        c_o   = ext_s[DATA_W];
      end
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      default: y_o = a_i;
    endcase
  end

  assign z_o = (y_o == '0);

endmodule

// File: rtl/cpu_core_param.sv
// Accumulator CPU core: req/valid instruction fetch, back-pressured output port, HALT.
// Define CPU_CALLSTACK_EN to give opcodes C/D CALL/RET semantics with a STACK_DEPTH-entry stack.
module cpu_core_param
  import cpu_core_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           imem_req,
  output logic [ADDR_W-1:0]              imem_addr,
  input  logic                           imem_valid,
  input  logic [instr_width(DATA_W)-1:0] imem_data,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           halted,
  output logic                           stack_err
);

  localparam int INSTR_W = instr_width(DATA_W);

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [DATA_W-1:0]  acc_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               zf_q;
  logic               cf_q;
  logic               out_valid_q;
  logic               halted_q;

  logic [3:0]         opcode_s;
  logic [DATA_W-1:0]  imm_s;
  logic [ADDR_W-1:0]  target_s;
  alu_op_e            alu_op_s;
  logic               alu_wr_s;
  logic [DATA_W-1:0]  alu_y_s;
  logic               alu_z_s;
  logic               alu_c_s;
  logic               unused_rsvd_s;

  assign opcode_s      = ir_q[INSTR_W-1 -: 4];
  assign imm_s         = ir_q[DATA_W-1:0];
  assign target_s      = imm_s[ADDR_W-1:0];
  assign unused_rsvd_s = ^ir_q[DATA_W+3:DATA_W];

`ifdef CPU_CALLSTACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
  logic [SP_W-1:0]    sp_q;
  logic [SP_W-1:0]    sp_dec_s;
  logic               stack_err_q;

  assign sp_dec_s  = sp_q - SP_W'(1);
  assign stack_err = stack_err_q;
`else
  localparam int unused_depth_lp = STACK_DEPTH;

  assign stack_err = 1'b0;
`endif

  // Map opcodes onto ALU operations; only data operations write acc and flags
  always_comb begin
    alu_op_s = ALU_NONE;
    alu_wr_s = 1'b0;
    case (opcode_s)
      OP_LOAD: begin alu_op_s = ALU_PASS; alu_wr_s = 1'b1; end
      OP_ADD:  begin alu_op_s = ALU_ADD;  alu_wr_s = 1'b1; end
      OP_SUB:  begin alu_op_s = ALU_SUB;  alu_wr_s = 1'b1; end
      OP_AND:  begin alu_op_s = ALU_AND;  alu_wr_s = 1'b1; end
      OP_OR:   begin alu_op_s = ALU_OR;   alu_wr_s = 1'b1; end
      OP_XOR:  begin alu_op_s = ALU_XOR;  alu_wr_s = 1'b1; end
      default: begin alu_op_s = ALU_NONE; alu_wr_s = 1'b0; end
    endcase
  end

  cpu_alu_w #(.DATA_W(DATA_W)) u_alu (
    .a_i  (acc_q),
    .b_i  (imm_s),
    .op_i (alu_op_s),
    .y_o  (alu_y_s),
    .z_o  (alu_z_s),
    .c_o  (alu_c_s)
  );

  // Core FSM: fetch / decode / execute plus output handshake and halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      zf_q        <= 1'b1;
      cf_q        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
`ifdef CPU_CALLSTACK_EN
      sp_q        <= '0;
      stack_err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
`endif
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            ir_q    <= imem_data;
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= S_DECODE;
          end
        end
        S_DECODE: state_q <= S_EXEC;
        S_EXEC: begin
          state_q <= S_FETCH;
          if (alu_wr_s) begin
            acc_q <= alu_y_s;
            zf_q  <= alu_z_s;
            cf_q  <= alu_c_s;
          end
          case (opcode_s)
            OP_JMP: pc_q <= target_s;
            OP_JZ:  if (zf_q)  pc_q <= target_s;
            OP_JNZ: if (!zf_q) pc_q <= target_s;
            OP_JC:  if (cf_q)  pc_q <= target_s;
            OP_OUT: begin
              out_data_q  <= acc_q;
              out_valid_q <= 1'b1;
              state_q     <= S_OUT_WAIT;
            end
            OP_HALT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
`ifdef CPU_CALLSTACK_EN
            // pc already points past the CALL, so it is the return address
            OP_CALL: begin
              if (sp_q == SP_W'(STACK_DEPTH)) begin
                stack_err_q <= 1'b1;
              end else begin
                stack_q[sp_q[IDX_W-1:0]] <= pc_q;
                sp_q                     <= sp_q + SP_W'(1);
                pc_q                     <= target_s;
              end
            end
            OP_RET: begin
              if (sp_q == '0) begin
                stack_err_q <= 1'b1;
              end else begin
                pc_q <= stack_q[sp_dec_s[IDX_W-1:0]];
                sp_q <= sp_dec_s;
              end
            end
`endif
            default: ;
          endcase
        end
        S_OUT_WAIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_FETCH;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_core_param.sv
// Randomised and directed bench for cpu_core_param against an instruction-level reference model.
`timescale 1ns/1ps
module tb_cpu_core_param;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int SD = 4;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid = 1'b0;
  logic [IW-1:0] imem_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          halted;
  logic          stack_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem [256];
  int mpc, macc, mzf, mcf, mhalt, merr;
  int mstack[$];
  int exp_out[$];
  int fetch_log[$];
  int out_log[$];
  int ov_cycles;

  cpu_core_param #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int q_at(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  // Instruction-level reference: executes one whole instruction with plain integer arithmetic
  function automatic void model_step(input logic [15:0] w);
    int op  = int'(w[15:12]);
    int imm = int'(w[7:0]);
    int s;
    mpc = (mpc + 1) % 256;
    case (op)
      1:  begin macc = imm; mcf = 0; end
      2:  begin s = macc + imm; mcf = (s > 255) ? 1 : 0; macc = s % 256; end
      3:  begin mcf = (macc < imm) ? 1 : 0; macc = (macc - imm + 256) % 256; end
      4:  begin macc = macc & imm; mcf = 0; end
      5:  begin macc = macc | imm; mcf = 0; end
      9:  begin macc = macc ^ imm; mcf = 0; end
      6:  mpc = imm;
      7:  if (mzf != 0) mpc = imm;
      10: if (mzf == 0) mpc = imm;
      11: if (mcf != 0) mpc = imm;
      8:  exp_out.push_back(macc);
      15: mhalt = 1;
`ifdef CPU_CALLSTACK_EN
      12: if (mstack.size() == SD) merr = 1; else begin mstack.push_back(mpc); mpc = imm; end
      13: if (mstack.size() == 0) merr = 1; else mpc = mstack.pop_back();
`endif
      default: ;
    endcase
    if (op inside {1, 2, 3, 4, 5, 9}) mzf = (macc == 0) ? 1 : 0;
  endfunction

  task automatic prog_clear();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_imem_req", imem_req, 1);
    check_eq("rst_imem_addr", imem_addr, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_stack_err", stack_err, 0);
    rst_n = 1'b1;
  endtask

  // Drives memory and consumer each negedge, checking the DUT against the model on every handshake
  task automatic run_prog(input string name, input int max_cycles, input bit need_halt,
                          input int wmin, input int wmax, input int rdy_pct, input int rdy_delay);
    int wait_cnt = 0;
    bit pending  = 1'b0;
    int last_hs  = -1;
    int last_op  = 0;
    int vcnt     = 0;
    int hcnt     = 0;
    bit done     = 1'b0;
    bit zero_lat = (wmax == 0) && (rdy_pct == 100) && (rdy_delay < 0);
    do_reset();
    mpc = 0; macc = 0; mzf = 1; mcf = 0; mhalt = 0; merr = 0; ov_cycles = 0;
    mstack.delete(); exp_out.delete(); fetch_log.delete(); out_log.delete();
    for (int cyc = 0; cyc < max_cycles && !done; cyc++) begin
      if (mhalt != 0) check_eq({name, " req_after_halt"}, imem_req, 0);
      if (imem_req) begin
        if (!pending) begin
          pending  = 1'b1;
          wait_cnt = int'($urandom_range(wmax, wmin));
        end
        if (wait_cnt == 0) begin
          imem_valid = 1'b1;
          imem_data  = mem[imem_addr];
          pending    = 1'b0;
        end else begin
          imem_valid = 1'b0;
          imem_data  = 16'($urandom);
          wait_cnt--;
        end
        if (mhalt == 0) check_eq({name, " fetch_addr"}, imem_addr, mpc);
      end else begin
        imem_valid = 1'($urandom_range(1, 0));
        imem_data  = 16'($urandom);
      end
      if (rdy_delay >= 0) out_ready = out_valid ? (vcnt >= rdy_delay) : 1'($urandom_range(1, 0));
      else out_ready = ($urandom_range(99, 0) < 32'(rdy_pct));

      if (imem_req && imem_valid && mhalt == 0) begin
        check_eq({name, " stack_err"}, stack_err, merr);
        if (zero_lat && last_hs >= 0) check_eq({name, " latency"}, cyc - last_hs, (last_op == 8) ? 4 : 3);
        fetch_log.push_back(int'(imem_addr));
        last_op = int'(mem[imem_addr][15:12]);
        last_hs = cyc;
        model_step(mem[imem_addr]);
      end

      if (out_valid) begin
        ov_cycles++;
        if (exp_out.size() == 0) check_eq({name, " unexpected_out"}, out_valid, 0);
        else check_eq({name, " out_data"}, out_data, exp_out[0]);
        if (out_ready) begin
          out_log.push_back(int'(out_data));
          if (exp_out.size() > 0) void'(exp_out.pop_front());
          vcnt = 0;
        end else begin
          vcnt++;
        end
      end

      if (mhalt != 0 && halted) hcnt++;
      if (hcnt >= 3) done = 1'b1;
      if (!done) @(negedge clk);
    end
    if (need_halt) check_eq({name, " halt_reached"}, done, 1);
    if (done) begin
      check_eq({name, " halt_req_low"}, imem_req, 0);
      check_eq({name, " outs_drained"}, exp_out.size(), 0);
      check_eq({name, " final_stack_err"}, stack_err, merr);
    end
    imem_valid = 1'b0;
  endtask

  task automatic reset_mid_out();
    int vc = 0;
    prog_clear();
    mem[0] = 16'h1077;
    mem[1] = 16'h8000;
    do_reset();
    for (int i = 0; i < 40 && vc < 3; i++) begin
      imem_valid = imem_req;
      imem_data  = mem[imem_addr];
      out_ready  = 1'b0;
      if (out_valid) vc++;
      if (vc < 3) @(negedge clk);
    end
    check_eq("rmo out_valid_pending", out_valid, 1);
    check_eq("rmo out_data_held", out_data, 32'h77);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rmo out_valid_cleared", out_valid, 0);
    check_eq("rmo imem_req", imem_req, 1);
    check_eq("rmo imem_addr", imem_addr, 0);
    @(negedge clk);
    rst_n      = 1'b1;
    imem_valid = 1'b1;
    imem_data  = mem[0];
    check_eq("rmo restart_addr", imem_addr, 0);
    @(negedge clk);
    imem_valid = 1'b0;
    check_eq("rmo after_fetch_addr", imem_addr, 1);
    check_eq("rmo after_fetch_req", imem_req, 0);
  endtask

  initial begin
    // LOAD FF (nonzero reserved bits); ADD 01 -> 0, zf=1, cf=1; JC 10; JZ 20; OUT
    prog_clear();
    mem[0] = 16'h1AFF; mem[1] = 16'h2001; mem[2] = 16'hB010;
    mem[16] = 16'h7020; mem[32] = 16'h8000;
    run_prog("carry", 200, 1'b1, 0, 0, 100, -1);
    check_eq("carry jc_target", q_at(fetch_log, 3), 32'h10);
    check_eq("carry jz_target", q_at(fetch_log, 4), 32'h20);
    check_eq("carry out", q_at(out_log, 0), 32'h00);

    // LOAD 03; SUB 05 -> FE, cf=1, zf=0; JC 08; JNZ 20 taken; JZ 30 not taken; OUT
    prog_clear();
    mem[0] = 16'h1003; mem[1] = 16'h3005; mem[2] = 16'hB008;
    mem[8] = 16'hA020; mem[32] = 16'h7030; mem[33] = 16'h8000;
    run_prog("borrow", 300, 1'b1, 0, 2, 50, -1);
    check_eq("borrow jc_target", q_at(fetch_log, 3), 32'h08);
    check_eq("borrow jnz_target", q_at(fetch_log, 4), 32'h20);
    check_eq("borrow jz_fallthru", q_at(fetch_log, 5), 32'h21);
    check_eq("borrow out", q_at(out_log, 0), 32'hFE);

    prog_clear();
    mem[0] = 16'h1042; mem[1] = 16'h8000;
    run_prog("wait3", 300, 1'b1, 3, 3, 100, -1);
    check_eq("wait3 fetches", fetch_log.size(), 3);
    check_eq("wait3 out", q_at(out_log, 0), 32'h42);

    prog_clear();
    mem[0] = 16'h105A; mem[1] = 16'h8000;
    run_prog("backpr", 300, 1'b1, 0, 0, 100, 5);
    check_eq("backpr transfers", out_log.size(), 1);
    check_eq("backpr out", q_at(out_log, 0), 32'h5A);
    check_eq("backpr valid_cycles", ov_cycles, 6);

    // JNZ 10 not taken (zf=1); LOAD 01; JMP FF; NOP at FF wraps to 00; JNZ 10 now taken
    prog_clear();
    mem[0] = 16'hA010; mem[1] = 16'h1001; mem[2] = 16'h60FF; mem[255] = 16'h0000;
    run_prog("wrap", 300, 1'b1, 0, 1, 80, -1);
    check_eq("wrap after_ff", q_at(fetch_log, 4), 32'h00);
    check_eq("wrap taken", q_at(fetch_log, 5), 32'h10);
    check_eq("wrap halted", halted, 1);

    reset_mid_out();

`ifdef CPU_CALLSTACK_EN
    prog_clear();
    mem[0] = 16'hC010; mem[16] = 16'hC020; mem[32] = 16'hC030; mem[48] = 16'hC040;
    mem[64] = 16'hC050; mem[65] = 16'hD000; mem[49] = 16'hD000; mem[33] = 16'hD000;
    mem[17] = 16'hD000; mem[1] = 16'h1033; mem[2] = 16'h8000; mem[3] = 16'hD000;
    run_prog("stack", 500, 1'b1, 0, 1, 70, -1);
    check_eq("stack overflow_skip", q_at(fetch_log, 5), 32'h41);
    check_eq("stack ret1", q_at(fetch_log, 6), 32'h31);
    check_eq("stack ret_last", q_at(fetch_log, 9), 32'h01);
    check_eq("stack err", stack_err, 1);
    check_eq("stack out", q_at(out_log, 0), 32'h33);
`else
    prog_clear();
    mem[0] = 16'hC010; mem[1] = 16'hD000; mem[2] = 16'h1033; mem[3] = 16'h8000;
    run_prog("nostack", 300, 1'b1, 0, 1, 70, -1);
    check_eq("nostack call_nop", q_at(fetch_log, 1), 32'h01);
    check_eq("nostack ret_nop", q_at(fetch_log, 2), 32'h02);
    check_eq("nostack err", stack_err, 0);
    check_eq("nostack out", q_at(out_log, 0), 32'h33);
`endif

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(99, 0) < 2) mem[i] = {4'hF, 4'($urandom), 8'($urandom)};
        else mem[i] = {4'($urandom_range(14, 0)), 4'($urandom), 8'($urandom)};
      end
      run_prog("rnd", 3000, 1'b0, 0, (k == 0) ? 0 : 2, (k == 0) ? 100 : 60, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
